// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: captures decode fields, forwards MEM/WB results, drives ALU SrcA/SrcB/ALUControl.
// One-cycle latency, stalls via ready = !valid || ex_ready; MEM forwarding only with ALU_OPERAND_MEM_FWD_EN.
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_id_valid,
    output logic            o_id_ready,
    input  logic [RA_W-1:0] i_id_rs1_addr,
    input  logic [RA_W-1:0] i_id_rs2_addr,
    input  logic [XLEN-1:0] i_id_rs1_data,
    input  logic [XLEN-1:0] i_id_rs2_data,
    input  logic [XLEN-1:0] i_id_imm,
    input  logic [XLEN-1:0] i_id_pc,
    input  logic            i_id_asel_pc,
    input  logic            i_id_bsel_imm,
    input  logic [3:0]      i_id_alu_ctrl,
    input  logic [RA_W-1:0] i_id_rd_addr,
    input  logic            i_id_reg_write,
    input  logic            i_mem_fwd_valid,
    input  logic [RA_W-1:0] i_mem_fwd_rd,
    input  logic [XLEN-1:0] i_mem_fwd_data,
    input  logic            i_wb_fwd_valid,
    input  logic [RA_W-1:0] i_wb_fwd_rd,
    input  logic [XLEN-1:0] i_wb_fwd_data,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_SrcA,
    output logic [XLEN-1:0] o_SrcB,
    output logic [3:0]      o_ALUControl,
    output logic [XLEN-1:0] o_store_data,
    output logic [RA_W-1:0] o_rd_addr,
    output logic            o_reg_write,
    output logic [XLEN-1:0] o_pc
);

    typedef struct packed {
        logic [RA_W-1:0] rs1_addr;
        logic [RA_W-1:0] rs2_addr;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            asel_pc;
        logic            bsel_imm;
        logic [3:0]      alu_ctrl;
        logic [RA_W-1:0] rd_addr;
        logic            reg_write;
    } hold_t;

    hold_t held;
    hold_t incoming;
    logic  ex_valid;
    logic  capture;
    logic  stalled;
    logic  mem_hit_rs1, mem_hit_rs2;
    logic  wb_hit_rs1, wb_hit_rs2;
    logic  refresh_rs1, refresh_rs2;

    assign o_id_ready = !ex_valid || i_ex_ready;
    assign capture    = i_id_valid && o_id_ready && !i_flush;
    assign stalled    = ex_valid && !i_ex_ready;

    // A zero source address never matches, so x0 always reads the register file.
`ifdef ALU_OPERAND_MEM_FWD_EN
    assign mem_hit_rs1 = i_mem_fwd_valid && (i_mem_fwd_rd == i_id_rs1_addr) && (|i_id_rs1_addr);
    assign mem_hit_rs2 = i_mem_fwd_valid && (i_mem_fwd_rd == i_id_rs2_addr) && (|i_id_rs2_addr);
`else
    logic unused_mem_bus;
    assign unused_mem_bus = ^{i_mem_fwd_valid, i_mem_fwd_rd, i_mem_fwd_data};
    assign mem_hit_rs1    = 1'b0;
    assign mem_hit_rs2    = 1'b0;
`endif
    assign wb_hit_rs1  = i_wb_fwd_valid && (i_wb_fwd_rd == i_id_rs1_addr) && (|i_id_rs1_addr);
    assign wb_hit_rs2  = i_wb_fwd_valid && (i_wb_fwd_rd == i_id_rs2_addr) && (|i_id_rs2_addr);
    assign refresh_rs1 = stalled && i_wb_fwd_valid && (i_wb_fwd_rd == held.rs1_addr) && (|held.rs1_addr);
    assign refresh_rs2 = stalled && i_wb_fwd_valid && (i_wb_fwd_rd == held.rs2_addr) && (|held.rs2_addr);

    always_comb begin
        incoming           = '0;
        incoming.rs1_addr  = i_id_rs1_addr;
        incoming.rs2_addr  = i_id_rs2_addr;
        incoming.rs1_val   = mem_hit_rs1 ? i_mem_fwd_data :
                             wb_hit_rs1  ? i_wb_fwd_data  : i_id_rs1_data;
        incoming.rs2_val   = mem_hit_rs2 ? i_mem_fwd_data :
                             wb_hit_rs2  ? i_wb_fwd_data  : i_id_rs2_data;
        incoming.imm       = i_id_imm;
        incoming.pc        = i_id_pc;
        incoming.asel_pc   = i_id_asel_pc;
        incoming.bsel_imm  = i_id_bsel_imm;
        incoming.alu_ctrl  = i_id_alu_ctrl;
        incoming.rd_addr   = i_id_rd_addr;
        incoming.reg_write = i_id_reg_write;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid <= 1'b0;
            held     <= '0;
        end else begin
            if (i_flush)         ex_valid <= 1'b0;
            else if (capture)    ex_valid <= 1'b1;
            else if (i_ex_ready) ex_valid <= 1'b0;

            if (capture) begin
                held <= incoming;
            end else if (!i_flush) begin
                // WB result arriving while we wait on EX would otherwise be lost.
                if (refresh_rs1) held.rs1_val <= i_wb_fwd_data;
                if (refresh_rs2) held.rs2_val <= i_wb_fwd_data;
            end
        end
    end

    assign o_ex_valid   = ex_valid;
    assign o_SrcA       = held.asel_pc  ? held.pc  : held.rs1_val;
    assign o_SrcB       = held.bsel_imm ? held.imm : held.rs2_val;
    assign o_store_data = held.rs2_val;
    assign o_ALUControl = ex_valid ? held.alu_ctrl : 4'b0000;
    assign o_reg_write  = ex_valid && held.reg_write;
    assign o_rd_addr    = held.rd_addr;
    assign o_pc         = held.pc;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It captures decoded instruction fields and register-file read data, and resolves data hazards by forwarding from the MEM and WB result buses. It selects the final operands and drives the ALU's `SrcA`, `SrcB` and `ALUControl` inputs. Decode and the EX consumer are decoupled by a valid/ready handshake, and the block supports stall and flush.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_flush  in  1  discard held and incoming instruction
- i_id_valid  in  1  decode offers an instruction
- o_id_ready  out  1  stage can accept this cycle
- i_id_rs1_addr, i_id_rs2_addr  in  RA_W  source register numbers
- i_id_rs1_data, i_id_rs2_data  in  XLEN  register-file read data
- i_id_imm  in  XLEN  sign-extended immediate
- i_id_pc  in  XLEN  instruction PC
- i_id_asel_pc  in  1  SrcA = PC instead of rs1
- i_id_bsel_imm  in  1  SrcB = imm instead of rs2
- i_id_alu_ctrl  in  4  ALU operation code (ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0101)
- i_id_rd_addr  in  RA_W  destination register
- i_id_reg_write  in  1  instruction writes rd
- i_mem_fwd_valid, i_mem_fwd_rd, i_mem_fwd_data  in  1/RA_W/XLEN  MEM-stage result bus
- i_wb_fwd_valid, i_wb_fwd_rd, i_wb_fwd_data  in  1/RA_W/XLEN  WB-stage result bus
- o_ex_valid  out  1  operands valid for ALU
- i_ex_ready  in  1  EX consumes this cycle
- o_SrcA, o_SrcB  out  XLEN  ALU operands
- o_ALUControl  out  4  ALU operation code
- o_store_data  out  XLEN  forwarded rs2 value, independent of the SrcB select
- o_rd_addr  out  RA_W  held destination register
- o_reg_write  out  1  held write enable
- o_pc  out  XLEN  held PC

## Operation
- Accept: `o_id_ready = !o_ex_valid || i_ex_ready` (combinational). The stage captures when `i_id_valid && o_id_ready && !i_flush`.
- Capture-time forwarding, per source operand:
  - If the MEM bus is valid, its rd matches the source address, and rd≠0, take the MEM data.
  - Otherwise, if the WB bus is valid, its rd matches, and rd≠0, take the WB data.
  - Otherwise take the register-file data.
  - MEM has priority over WB.
- Register x0 is never forwarded: a source address of 0 always yields the register-file data.
- Hold-time refresh: while `o_ex_valid && !i_ex_ready`, a valid WB bus write whose rd matches a held, nonzero source address overwrites that held rs1/rs2 value.
- Output muxing is combinational from held state:
  - `o_SrcA = asel_pc ? pc : rs1_val`
  - `o_SrcB = bsel_imm ? imm : rs2_val`
  - `o_store_data = rs2_val`
- Valid register:
  - Next value is 1 on capture.
  - Otherwise next value is 0 if `i_ex_ready`.
  - Otherwise it holds.
- Flush:
  - `o_ex_valid` goes to 0 on the next edge.
  - Any same-cycle capture is dropped.
  - Flush overrides `i_ex_ready` and refresh.
- Payload registers update only on capture. `o_ALUControl` and `o_reg_write` are qualified with valid: they are forced to 0 when `o_ex_valid` is 0, so a bubble never writes.
- Load-use hazards are out of scope here. Decode withholds `i_id_valid` for them.

## Timing
- Latency is one cycle from an accepted ID beat to `o_ex_valid`.
- Throughput is one instruction per cycle when `i_ex_ready` is held high.
- Simultaneous consume and capture: back-to-back transfer with no bubble.
- Forwarding buses are sampled in the capture cycle only, plus WB refresh during hold. Values presented after capture have no effect unless a refresh occurs.
- Reset value of every output is 0: `o_ex_valid`, `o_SrcA`, `o_SrcB`, `o_ALUControl`, `o_store_data`, `o_rd_addr`, `o_reg_write`, `o_pc`.
- `o_id_ready` is 1 during and after reset.
- Reset mid-hold discards the held instruction.
- Reset has priority over flush; flush has priority over capture.

## Configuration
- `ALU_OPERAND_MEM_FWD_EN` defined: the MEM-bus forwarding path is built as described above.
- Not defined:
  - The MEM-bus inputs are ignored.
  - Only WB forwarding and WB refresh exist.
  - Decode must stall for one extra cycle on EX→EX dependences.

## Test plan
- Reset, then a single ADD with rs1=x1=5 and rs2=x2=7, no forwarding: one cycle later `o_ex_valid=1`, `o_SrcA=5`, `o_SrcB=7`, `o_ALUControl=0000`.
- Forwarding priority, with rs1=x3, rf data 1, WB bus {x3, 2}, MEM bus {x3, 9}: `o_SrcA=9`. With the MEM bus invalid, `o_SrcA=2`. With rs1=x0 and both buses targeting x0, `o_SrcA` equals the rf data.
- Stall with refresh, rs2=x4 captured as 3 and `i_ex_ready=0` for 3 cycles:
  - A WB write {x4, 0x55} in cycle 2 gives `o_SrcB=0x55` from then on.
  - `o_id_ready=0` throughout the stall.
  - The incoming instruction is held off until ready.
- Immediate/PC select, with `asel_pc=1`, `bsel_imm=1`, pc=0x100, imm=0xFFFFFFFC: `o_SrcA=0x100`, `o_SrcB=0xFFFFFFFC`, and `o_store_data` equals the forwarded rs2.
- Flush and streaming:
  - Stream 4 instructions with `i_ex_ready=1` and check 4 consecutive valids.
  - Assert `i_flush` together with a new `i_id_valid`: the next cycle has `o_ex_valid=0`, `o_reg_write=0`, and the flushed instruction never appears.
- With `ALU_OPERAND_MEM_FWD_EN` undefined, rerun the priority test: `o_SrcA=2` (WB value) despite a valid MEM match.
